// File: rtl/msdap_if.sv
// msdap stereo sample/serial-result bus: word-parallel input side plus
// the serial result side. Sclk and Reset_n are plain ports on the core.
interface msdap_if;
  logic        Dclk;
  logic        Start;
  logic        Frame;
  logic [15:0] InputL;
  logic [15:0] InputR;
  logic        InReady;
  logic        OutReady;
  logic        OutputL;
  logic        OutputR;

  modport master (
    output Dclk, Start, Frame, InputL, InputR,
    input  InReady, OutReady, OutputL, OutputR
  );

  modport slave (
    input  Dclk, Start, Frame, InputL, InputR,
    output InReady, OutReady, OutputL, OutputR
  );
endinterface

// File: rtl/msdap.sv
// msdap: two-channel POT-weighted FIR. Loads 16 rj group counts and 512
// signed-delay coefficients per channel, then filters each stereo sample
// and shifts the 40-bit results out MSB first.
module msdap (
  input logic    Sclk,
  input logic    Reset_n,
  msdap_if.slave bus
);

  typedef enum logic [2:0] {
    CLEAR, WAIT_RJ, READ_RJ, READ_COEF, WAIT_DATA, WORK, OUT, SLEEP
  } state_t;

  localparam logic [9:0] ZERO_LIMIT = 10'd800;

  state_t      state;
  logic [2:0]  dSync;
  logic        dclkRise;
  logic        capture;
  logic        sampleZero;
  logic        configDone;
  logic [7:0]  clrIdx;
  logic [7:0]  wPtr;
  logic [7:0]  cur;
  logic [3:0]  rjIdx;
  logic [8:0]  coefIdx;
  logic        pending;
  logic [9:0]  zeroCnt;
  logic [5:0]  bitCnt;
  logic        allDone;
  logic        loadOut;
  logic        zeroLoad;
  logic        shiftOut;
  logic        endOut;
  logic [15:0] wordIn [2];

  assign dclkRise   = dSync[1] & ~dSync[2];
  assign capture    = dclkRise & bus.Frame & bus.InReady;
  assign sampleZero = (bus.InputL == '0) && (bus.InputR == '0);
  assign wordIn[0]  = bus.InputL;
  assign wordIn[1]  = bus.InputR;
  assign allDone    = g_chan[0].finish & g_chan[1].finish;
  assign loadOut    = (state == WORK) && allDone;
  assign zeroLoad   = (state == SLEEP) && capture && sampleZero;
  assign shiftOut   = (state == OUT) && (bitCnt != '0);
  assign endOut     = (state == OUT) && (bitCnt == '0);
  assign bus.OutputL = g_chan[0].serBit;
  assign bus.OutputR = g_chan[1].serBit;

  // Configuration-valid flag: survives Reset_n, cleared only by Start.
  always_ff @(posedge Sclk) begin
    if (!bus.Start)
      configDone <= 1'b0;
    else if (state == READ_COEF && capture && coefIdx == '1)
      configDone <= 1'b1;
  end

  // Control FSM: Dclk synchronizer, load sequencing, sample scheduling, output framing.
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= CLEAR;
      dSync        <= '0;
      clrIdx       <= '0;
      wPtr         <= '0;
      cur          <= '0;
      rjIdx        <= '0;
      coefIdx      <= '0;
      pending      <= 1'b0;
      zeroCnt      <= '0;
      bitCnt       <= '0;
      bus.InReady  <= 1'b0;
      bus.OutReady <= 1'b0;
    end else begin
      dSync <= {dSync[1:0], bus.Dclk};
      if (!bus.Start) begin
        state        <= CLEAR;
        clrIdx       <= '0;
        pending      <= 1'b0;
        zeroCnt      <= '0;
        bus.InReady  <= 1'b0;
        bus.OutReady <= 1'b0;
      end else begin
        if (capture && (state inside {WAIT_DATA, WORK, OUT, SLEEP})) begin
          wPtr <= wPtr + 8'd1;
          if (!sampleZero)
            zeroCnt <= '0;
          else if (zeroCnt != ZERO_LIMIT)
            zeroCnt <= zeroCnt + 10'd1;
        end
        case (state)
          CLEAR: begin
            clrIdx <= clrIdx + 8'd1;
            if (clrIdx == '1) begin
              bus.InReady <= 1'b1;
              rjIdx       <= '0;
              coefIdx     <= '0;
              pending     <= 1'b0;
              state       <= configDone ? WAIT_DATA : WAIT_RJ;
            end
          end
          WAIT_RJ: if (capture) begin
            rjIdx <= 4'd1;
            state <= READ_RJ;
          end
          READ_RJ: if (capture) begin
            rjIdx <= rjIdx + 4'd1;
            if (rjIdx == 4'd15) state <= READ_COEF;
          end
          READ_COEF: if (capture) begin
            coefIdx <= coefIdx + 9'd1;
            if (coefIdx == '1) state <= WAIT_DATA;
          end
          WAIT_DATA: if (capture) begin
            cur   <= wPtr;
            state <= WORK;
          end
          SLEEP: if (capture) begin
            cur <= wPtr;
            if (sampleZero) begin
              bus.OutReady <= 1'b1;
              bitCnt       <= 6'd39;
              state        <= OUT;
            end else begin
              state <= WORK;
            end
          end
          WORK: begin
            if (capture) pending <= 1'b1;
            if (allDone) begin
              bus.OutReady <= 1'b1;
              bitCnt       <= 6'd39;
              state        <= OUT;
            end
          end
          OUT: begin
            if (bitCnt != '0) begin
              bitCnt <= bitCnt - 6'd1;
              if (capture) pending <= 1'b1;
            end else begin
              bus.OutReady <= 1'b0;
              // A word landing on the last bit cycle is taken as the pending one.
              if (pending || capture) begin
                cur     <= cur + 8'd1;
                pending <= 1'b0;
                state   <= WORK;
              end else if (zeroCnt >= ZERO_LIMIT) begin
                state <= SLEEP;
              end else begin
                state <= WAIT_DATA;
              end
            end
          end
          default: state <= CLEAR;
        endcase
      end
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [7:0]  rjMem   [16];
    logic [8:0]  coefMem [512];
    logic [15:0] dataMem [256];
    logic [3:0]  group;
    logic [7:0]  remain;
    logic [8:0]  cIdx;
    logic [39:0] acc;
    logic [39:0] u;
    logic [39:0] shReg;
    logic        chDone;
    logic        serBit;
    logic        finish;
    logic [8:0]  cw;
    logic [7:0]  rdAddr;
    logic [15:0] xs;
    logic [39:0] xExt;
    logic [39:0] uNext;
    logic [39:0] accStep;
    logic [39:0] res;

    assign finish = chDone | ((remain == '0) && (group == 4'd15));

    // One coefficient term and one group shift, evaluated per cycle.
    always_comb begin
      cw      = coefMem[cIdx];
      rdAddr  = cur - cw[7:0];
      xs      = dataMem[rdAddr];
      xExt    = {{8{xs[15]}}, xs, 16'h0000};
      uNext   = cw[8] ? (u - xExt) : (u + xExt);
      accStep = 40'($signed(acc + u) >>> 1);
      res     = chDone ? acc : accStep;
    end

    // Memory writes: history clear, rj/coef load, sample store.
    always_ff @(posedge Sclk) begin
      if (state == CLEAR)
        dataMem[clrIdx] <= '0;
      else if (capture) begin
        case (state)
          WAIT_RJ, READ_RJ:             rjMem[rjIdx]     <= wordIn[ch][7:0];
          READ_COEF:                    coefMem[coefIdx] <= wordIn[ch][8:0];
          WAIT_DATA, WORK, OUT, SLEEP:  dataMem[wPtr]    <= wordIn[ch];
          default: ;
        endcase
      end
    end

    // Channel datapath and serializer.
    // Sequencer registers are re-primed every non-WORK cycle so WORK starts
    // on its first computing cycle with no separate init step.
    always_ff @(posedge Sclk or negedge Reset_n) begin
      if (!Reset_n) begin
        group  <= '0;
        remain <= '0;
        cIdx   <= '0;
        acc    <= '0;
        u      <= '0;
        chDone <= 1'b0;
        shReg  <= '0;
        serBit <= 1'b0;
      end else begin
        if (state != WORK) begin
          group  <= '0;
          remain <= rjMem[0];
          cIdx   <= '0;
          acc    <= '0;
          u      <= '0;
          chDone <= 1'b0;
        end else if (!chDone) begin
          if (remain != '0) begin
            u      <= uNext;
            cIdx   <= cIdx + 9'd1;
            remain <= remain - 8'd1;
          end else begin
            acc    <= accStep;
            u      <= '0;
            group  <= group + 4'd1;
            remain <= rjMem[group + 4'd1];
            if (group == 4'd15) chDone <= 1'b1;
          end
        end

        if (!bus.Start || endOut) begin
          serBit <= 1'b0;
        end else if (loadOut) begin
          shReg  <= res;
          serBit <= res[39];
        end else if (zeroLoad) begin
          shReg  <= '0;
          serBit <= 1'b0;
        end else if (shiftOut) begin
          shReg  <= shReg << 1;
          serBit <= shReg[38];
        end
      end
    end
  end

endmodule

// File: tb/tb_msdap.sv
// Scoreboard bench for msdap: directed stereo samples with hand-computed
// 40-bit results, checked by a serial-output monitor.
module tb_msdap;
  logic Sclk = 1'b0;
  logic Reset_n = 1'b0;
  msdap_if bus();

  msdap dut (.Sclk(Sclk), .Reset_n(Reset_n), .bus(bus));

  always #5 Sclk = ~Sclk;

  int total = 0;
  int bad = 0;
  logic [39:0] expL[$];
  logic [39:0] expR[$];
  logic expectAbort = 1'b0;

  int monCnt = 0;
  logic monJustDone = 1'b0;
  logic [39:0] shL = '0;
  logic [39:0] shR = '0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: assemble serial words on falling edges and pop the scoreboard.
  always @(negedge Sclk) begin
    if (monJustDone) begin
      check("outready_len", {39'd0, bus.OutReady}, 40'd0);
      monJustDone = 1'b0;
    end
    if (bus.OutReady === 1'b1) begin
      shL = {shL[38:0], bus.OutputL};
      shR = {shR[38:0], bus.OutputR};
      monCnt++;
      if (monCnt == 40) begin
        if (expL.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word actual=%h/%h required=none", shL, shR);
        end else begin
          check("word_L", shL, expL.pop_front());
          check("word_R", shR, expR.pop_front());
        end
        monCnt = 0;
        monJustDone = 1'b1;
      end
    end else if (monCnt != 0) begin
      check("word_abort", {39'd0, expectAbort}, 40'd1);
      monCnt = 0;
    end
  end

  task automatic sendWord(input logic [15:0] l, input logic [15:0] r);
    bus.Frame = 1'b1;
    bus.InputL = l;
    bus.InputR = r;
    bus.Dclk = 1'b1;
    repeat (4) @(posedge Sclk);
    #1;
    bus.Dclk = 1'b0;
    repeat (4) @(posedge Sclk);
    #1;
    bus.Frame = 1'b0;
  endtask

  task automatic sample(input logic [15:0] l, input logic [15:0] r,
                        input logic [39:0] eL, input logic [39:0] eR, input int gap);
    expL.push_back(eL);
    expR.push_back(eR);
    sendWord(l, r);
    repeat (gap) @(posedge Sclk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && expL.size() != 0; i++) @(posedge Sclk);
    #1;
    check("drain", 40'(expL.size()), 40'd0);
  endtask

  task automatic configure(input logic [8:0] coef0);
    bus.Start = 1'b0;
    @(posedge Sclk);
    #1;
    bus.Start = 1'b1;
    repeat (260) @(posedge Sclk);
    #1;
    check("cfg_inready", {39'd0, bus.InReady}, 40'd1);
    sendWord(16'h0001, 16'h0001);
    for (int i = 1; i < 16; i++) sendWord(16'h0000, 16'h0000);
    sendWord({7'd0, coef0}, {7'd0, coef0});
    for (int i = 1; i < 512; i++) sendWord(16'h0000, 16'h0000);
    repeat (10) @(posedge Sclk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    bus.Dclk = 1'b0;
    bus.Frame = 1'b0;
    bus.Start = 1'b1;
    bus.InputL = '0;
    bus.InputR = '0;
    repeat (3) @(posedge Sclk);
    #1;
    check("rst_inready",  {39'd0, bus.InReady},  40'd0);
    check("rst_outready", {39'd0, bus.OutReady}, 40'd0);
    check("rst_outL",     {39'd0, bus.OutputL},  40'd0);
    check("rst_outR",     {39'd0, bus.OutputR},  40'd0);
    Reset_n = 1'b1;
    repeat (250) @(posedge Sclk);
    #1;
    check("clear_busy", {39'd0, bus.InReady}, 40'd0);
    repeat (10) @(posedge Sclk);
    #1;
    check("clear_done", {39'd0, bus.InReady}, 40'd1);

    // rj0=1, coef0=+x(n): output is the sign-extended sample.
    configure(9'h000);
    sample(16'h4000, 16'h0123, 40'h0000004000, 40'h0000000123, 100);
    sample(16'hC000, 16'h8000, 40'hFFFFFFC000, 40'hFFFFFF8000, 100);
    sample(16'h7FFF, 16'hFFFF, 40'h0000007FFF, 40'hFFFFFFFFFF, 100);
    drain();

    // Reset_n pulse mid-output: word aborted, configuration kept.
    sendWord(16'h4000, 16'h4000);
    for (int i = 0; i < 300 && bus.OutReady !== 1'b1; i++) @(posedge Sclk);
    check("abort_outready_seen", {39'd0, bus.OutReady}, 40'd1);
    repeat (10) @(posedge Sclk);
    #2;
    expectAbort = 1'b1;
    Reset_n = 1'b0;
    #1;
    check("abort_outready", {39'd0, bus.OutReady}, 40'd0);
    check("abort_inready",  {39'd0, bus.InReady},  40'd0);
    check("abort_outL",     {39'd0, bus.OutputL},  40'd0);
    @(posedge Sclk);
    #1;
    Reset_n = 1'b1;
    repeat (3) @(posedge Sclk);
    #1;
    expectAbort = 1'b0;
    repeat (260) @(posedge Sclk);
    #1;
    check("resume_inready", {39'd0, bus.InReady}, 40'd1);
    sample(16'h4000, 16'hFFFE, 40'h0000004000, 40'hFFFFFFFFFE, 100);
    drain();

    // 800 zero samples into SLEEP, then the first nonzero sample is computed.
    for (int i = 0; i < 800; i++) sample(16'h0000, 16'h0000, 40'd0, 40'd0, 56);
    sample(16'h4000, 16'h0100, 40'h0000004000, 40'h0000000100, 100);
    drain();

    // Negative coefficient: output is -x.
    configure(9'h100);
    sample(16'h4000, 16'h0002, 40'hFFFFFFC000, 40'hFFFFFFFFFE, 100);
    drain();

    // k=1: output is the previous sample; second word arrives during OUT.
    configure(9'h001);
    sample(16'h4000, 16'h1111, 40'h0000000000, 40'h0000000000, 20);
    sample(16'h0000, 16'h2222, 40'h0000004000, 40'h0000001111, 150);
    sample(16'h0005, 16'h0000, 40'h0000000000, 40'h0000002222, 150);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
